// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// ----------------
// Shares the single register-file write port between two writeback sources:
// req0 (ALU/pipeline result) and req1 (multi-cycle unit such as load/mul).
// The winner of each cycle is accepted with a combinational ready, and its
// write (rd, data, enable) appears on the registered outputs one cycle later.
//
// Arbitration modes:
//   default              fixed priority to req0, with aging: once req1 has
//                        been refused MAX_WAIT cycles in a row it is forced
//                        to win.
//   `define WB_ARB_RR_EN pure round-robin between the two requesters; the
//                        aging counter is removed and MAX_WAIT is ignored.
//
// Ports:
//   clk, rst_n            clock and synchronous active-low reset
//   wb_hold               register file busy, blocks new grants
//   req0_valid/rd/data    request 0, req0_ready = accepted this cycle
//   req1_valid/rd/data    request 1, req1_ready = accepted this cycle
//   mux_sel               source of current wb_data (0 = req0, 1 = req1)
//   wb_en, wb_rd, wb_data registered register-file write (x0 never written)

module wb_port_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_hold,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_rd,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_rd,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              mux_sel,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data
);

    logic              grant0;
    logic              grant1;

    logic              mux_sel_d, mux_sel_q;
    logic              wb_en_d,   wb_en_q;
    logic [ADDR_W-1:0] wb_rd_d,   wb_rd_q;
    logic [DATA_W-1:0] wb_data_d, wb_data_q;

`ifdef WB_ARB_RR_EN
    logic              rr_ptr_d,  rr_ptr_q;
`else
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
    logic [3:0]        wait_cnt_d, wait_cnt_q;
`endif

    // Grant decision. Readies are held low during reset so an in-flight
    // request is not consumed by a cycle whose result is discarded.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n && !wb_hold) begin
`ifdef WB_ARB_RR_EN
            if (req0_valid && req1_valid) begin
                grant1 = rr_ptr_q;
                grant0 = !rr_ptr_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
`else
            if (req1_valid && (wait_cnt_q >= MAX_WAIT_C)) begin
                grant1 = 1'b1;
            end else if (req0_valid) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
`endif
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Next-state for the write register. Without a grant only the enable
    // drops; select, index and data keep their last values.
    always_comb begin
        mux_sel_d = mux_sel_q;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        wb_en_d   = 1'b0;
        if (grant1) begin
            mux_sel_d = 1'b1;
            wb_rd_d   = req1_rd;
            wb_data_d = req1_data;
            wb_en_d   = (req1_rd != '0);
        end else if (grant0) begin
            mux_sel_d = 1'b0;
            wb_rd_d   = req0_rd;
            wb_data_d = req0_data;
            wb_en_d   = (req0_rd != '0);
        end
    end

`ifdef WB_ARB_RR_EN
    // Prefer whichever requester did not win last.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant0) begin
            rr_ptr_d = 1'b1;
        end else if (grant1) begin
            rr_ptr_d = 1'b0;
        end
    end
`else
    // Count consecutive refused cycles of req1, hold cycles included,
    // saturating at MAX_WAIT so the forced grant stays armed.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!req1_valid || grant1) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q < MAX_WAIT_C) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mux_sel_q  <= 1'b0;
            wb_en_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
`ifdef WB_ARB_RR_EN
            rr_ptr_q   <= 1'b0;
`else
            wait_cnt_q <= 4'd0;
`endif
        end else begin
            mux_sel_q  <= mux_sel_d;
            wb_en_q    <= wb_en_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
`ifdef WB_ARB_RR_EN
            rr_ptr_q   <= rr_ptr_d;
`else
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

    assign mux_sel = mux_sel_q;
    assign wb_en   = wb_en_q;
    assign wb_rd   = wb_rd_q;
    assign wb_data = wb_data_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter
// -------------------
// Directed stimulus for wb_port_arbiter. A behavioural model predicts the
// readies and the registered write every cycle; literal expectations in the
// directed sequence pin the model to hand-computed values.
// Build with WB_ARB_RR_EN defined to exercise the round-robin variant.

module tb_wb_port_arbiter;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int MAX_WAIT = 4;

    logic              clk;
    logic              rst_n;
    logic              wb_hold;
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_rd;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_rd;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              mux_sel;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;

    int errors = 0;
    int checks = 0;

    wb_port_arbiter #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_hold    (wb_hold),
        .req0_valid (req0_valid),
        .req0_rd    (req0_rd),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_rd    (req1_rd),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .mux_sel    (mux_sel),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge.
    task automatic applyStimulus(input logic rstn, input logic hold,
                                 input logic v0, input logic [4:0] rd0,
                                 input logic [31:0] d0,
                                 input logic v1, input logic [4:0] rd1,
                                 input logic [31:0] d1);
        @(posedge clk);
        #1;
        rst_n      = rstn;
        wb_hold    = hold;
        req0_valid = v0;
        req0_rd    = rd0;
        req0_data  = d0;
        req1_valid = v1;
        req1_rd    = rd1;
        req1_data  = d1;
    endtask

    // Literal checks are taken just after the model compare point.
    task automatic sampleCycle;
        @(negedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: who must win this cycle, and what the register
    // file must see after the next edge.
    // ------------------------------------------------------------------
    logic              exp_en   = 1'b0;
    logic              exp_sel  = 1'b0;
    logic [ADDR_W-1:0] exp_rd   = '0;
    logic [DATA_W-1:0] exp_data = '0;
    int                refused  = 0;     // consecutive cycles req1 waited
    logic              prefer1  = 1'b0;  // round-robin preference
    logic              seen_reset = 1'b0;

    always @(negedge clk) begin
        logic win0, win1;
        win0 = 1'b0;
        win1 = 1'b0;
        if (rst_n && !wb_hold) begin
`ifdef WB_ARB_RR_EN
            if (req0_valid && req1_valid) begin
                win1 = prefer1;
                win0 = !prefer1;
            end else begin
                win0 = req0_valid;
                win1 = req1_valid;
            end
`else
            if (req1_valid && (refused >= MAX_WAIT || !req0_valid))
                win1 = 1'b1;
            else
                win0 = req0_valid;
`endif
        end

        if (seen_reset) begin
            checkOutput("model req0_ready", 32'(req0_ready), 32'(win0));
            checkOutput("model req1_ready", 32'(req1_ready), 32'(win1));
            checkOutput("model wb_en",      32'(wb_en),      32'(exp_en));
            checkOutput("model mux_sel",    32'(mux_sel),    32'(exp_sel));
            checkOutput("model wb_rd",      32'(wb_rd),      32'(exp_rd));
            checkOutput("model wb_data",    wb_data,         exp_data);
        end

        if (!rst_n) begin
            exp_en     = 1'b0;
            exp_sel    = 1'b0;
            exp_rd     = '0;
            exp_data   = '0;
            refused    = 0;
            prefer1    = 1'b0;
            seen_reset = 1'b1;
        end else begin
            if (win0 || win1) begin
                exp_sel  = win1;
                exp_rd   = win1 ? req1_rd : req0_rd;
                exp_data = win1 ? req1_data : req0_data;
                exp_en   = (exp_rd != 0);
                prefer1  = win0;
            end else begin
                exp_en = 1'b0;
            end
            if (req1_valid && !win1) refused = refused + 1;
            else                     refused = 0;
        end
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int n0;
        int n1;
        rst_n      = 1'b0;
        wb_hold    = 1'b0;
        req0_valid = 1'b0;
        req0_rd    = '0;
        req0_data  = '0;
        req1_valid = 1'b0;
        req1_rd    = '0;
        req1_data  = '0;

        // Reset with both requesters valid: nothing accepted.
        applyStimulus(0, 0, 1, 5'd3, 32'h11, 1, 5'd4, 32'h22);
        sampleCycle();
        checkOutput("rst ready0", 32'(req0_ready), 32'd0);
        checkOutput("rst ready1", 32'(req1_ready), 32'd0);
        applyStimulus(0, 0, 1, 5'd3, 32'h11, 1, 5'd4, 32'h22);
        sampleCycle();
        checkOutput("rst ready0 b", 32'(req0_ready), 32'd0);
        checkOutput("rst ready1 b", 32'(req1_ready), 32'd0);
        checkOutput("rst wb_en",    32'(wb_en),      32'd0);
        checkOutput("rst wb_rd",    32'(wb_rd),      32'd0);
        checkOutput("rst wb_data",  wb_data,         32'd0);
        checkOutput("rst mux_sel",  32'(mux_sel),    32'd0);
        applyStimulus(1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        sampleCycle();
        checkOutput("post-rst wb_en",   32'(wb_en),   32'd0);
        checkOutput("post-rst wb_data", wb_data,      32'd0);
        checkOutput("post-rst mux_sel", 32'(mux_sel), 32'd0);

        // Single req0 write.
        applyStimulus(1, 0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0);
        sampleCycle();
        checkOutput("single ready0", 32'(req0_ready), 32'd1);
        checkOutput("single ready1", 32'(req1_ready), 32'd0);
        applyStimulus(1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        sampleCycle();
        checkOutput("single wb_en",   32'(wb_en),   32'd1);
        checkOutput("single wb_rd",   32'(wb_rd),   32'd5);
        checkOutput("single wb_data", wb_data,      32'hDEADBEEF);
        checkOutput("single mux_sel", 32'(mux_sel), 32'd0);

        // req1 write to x0: accepted but never enabled.
        applyStimulus(1, 0, 0, 5'd0, 32'h0, 1, 5'd0, 32'h1234);
        sampleCycle();
        checkOutput("x0 ready1",     32'(req1_ready), 32'd1);
        checkOutput("single wb_en2", 32'(wb_en),      32'd0);

        // Hold for 3 cycles with req0 waiting.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 1, 5'd2, 32'hAAAA, 0, 5'd0, 32'h0);
            sampleCycle();
            checkOutput("hold ready0", 32'(req0_ready), 32'd0);
            if (i == 0) begin
                checkOutput("x0 wb_en",   32'(wb_en),   32'd0);
                checkOutput("x0 mux_sel", 32'(mux_sel), 32'd1);
                checkOutput("x0 wb_data", wb_data,      32'h1234);
            end
        end
        applyStimulus(1, 0, 1, 5'd2, 32'hAAAA, 0, 5'd0, 32'h0);
        sampleCycle();
        checkOutput("unhold ready0", 32'(req0_ready), 32'd1);
        // Hold rises again, but the registered write still lands.
        applyStimulus(1, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        sampleCycle();
        checkOutput("hold-rise wb_en", 32'(wb_en), 32'd1);
        checkOutput("hold-rise wb_rd", 32'(wb_rd), 32'd2);

        // Reset in the same cycle as a req1 request to x7.
        applyStimulus(0, 0, 0, 5'd0, 32'h0, 1, 5'd7, 32'h77);
        sampleCycle();
        checkOutput("rst-mid ready1", 32'(req1_ready), 32'd0);
        applyStimulus(1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        sampleCycle();
        checkOutput("rst-mid wb_en", 32'(wb_en), 32'd0);
        checkOutput("rst-mid wb_rd", 32'(wb_rd), 32'd0);
        applyStimulus(1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        sampleCycle();
        checkOutput("rst-mid wb_en2", 32'(wb_en), 32'd0);

`ifdef WB_ARB_RR_EN
        // Both valid for 6 cycles: strict alternation starting with req0.
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 0, 1, 5'(1 + n0), 32'(100 + n0),
                          1, 5'(9 + n1), 32'(200 + n1));
            sampleCycle();
            checkOutput("rr ready0", 32'(req0_ready), 32'((i % 2) == 0));
            checkOutput("rr ready1", 32'(req1_ready), 32'((i % 2) == 1));
            if (i > 0)
                checkOutput("rr mux_sel", 32'(mux_sel), 32'((i - 1) % 2));
            if (req0_ready) n0++;
            if (req1_ready) n1++;
        end
        applyStimulus(1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        sampleCycle();
        checkOutput("rr last mux_sel", 32'(mux_sel), 32'd1);
        checkOutput("rr last wb_rd",   32'(wb_rd),   32'd11);
`else
        // Aging: req0 wins MAX_WAIT cycles, then req1 is forced through.
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 1, 5'(1 + n0), 32'(100 + n0),
                          1, 5'd9, 32'h99);
            sampleCycle();
            checkOutput("age ready0", 32'(req0_ready), 32'(i < 4));
            checkOutput("age ready1", 32'(req1_ready), 32'(i == 4));
            if (i > 0) checkOutput("age wb_rd", 32'(wb_rd), 32'(i));
            if (req0_ready) n0++;
            if (req1_ready) n1++;
        end
        applyStimulus(1, 0, 1, 5'(1 + n0), 32'(100 + n0), 0, 5'd0, 32'h0);
        sampleCycle();
        checkOutput("age late ready0", 32'(req0_ready), 32'd1);
        checkOutput("age req1 wb_rd",  32'(wb_rd),      32'd9);
        checkOutput("age req1 mux",    32'(mux_sel),    32'd1);
        checkOutput("age req1 data",   wb_data,         32'h99);
        checkOutput("age req1 wb_en",  32'(wb_en),      32'd1);
        applyStimulus(1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        sampleCycle();
        checkOutput("age back wb_rd", 32'(wb_rd),   32'd5);
        checkOutput("age back mux",   32'(mux_sel), 32'd0);
`endif

        applyStimulus(1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        sampleCycle();
        checkOutput("idle wb_en", 32'(wb_en), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two writeback sources: req0, the ALU/pipeline result, and req1, a multi-cycle unit (load/mul).
- Arbitrates using valid/ready handshakes and drives the select of the 32-bit 2:1 writeback data mux.
- Registers the winning write (rd, data, enable) for the register file.
- Sits between the EX/MEM writeback stage and the register file.

Parameters:
- DATA_W, 32, writeback data width.
- ADDR_W, 5, register index width.
- MAX_WAIT, 4, cycles req1 may be refused before it is forced to win (fixed-priority mode only). Legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- wb_hold  in  1  register file busy; no grants are issued while high.
- req0_valid  in  1  req0 has a write pending.
- req0_rd  in  ADDR_W  req0 destination register.
- req0_data  in  DATA_W  req0 write data.
- req0_ready  out  1  req0 accepted this cycle (combinational).
- req1_valid  in  1  req1 has a write pending.
- req1_rd  in  ADDR_W  req1 destination register.
- req1_data  in  DATA_W  req1 write data.
- req1_ready  out  1  req1 accepted this cycle (combinational).
- mux_sel  out  1  source of the current wb_data: 0 = req0, 1 = req1 (registered).
- wb_en  out  1  register-file write enable (registered).
- wb_rd  out  ADDR_W  register-file write index (registered).
- wb_data  out  DATA_W  register-file write data (registered).

Behaviour:
- Reset (rst_n low at a clock edge): wb_en=0, wb_rd=0, wb_data=0, mux_sel=0, wait_cnt=0, rr_ptr=0.
  - req*_ready are forced to 0 while rst_n is low.
  - An in-flight grant in the reset cycle is discarded and not written.
- Handshake: a transfer occurs when reqN_valid && reqN_ready.
  - A requester keeps valid, rd and data stable until it is accepted.
  - At most one ready is high per cycle.
  - Ready is a function of the current valid inputs, wb_hold and internal state only.
- Grant, fixed-priority-with-aging mode (default):
  - wb_hold=1 → no grant.
  - else if req1_valid && wait_cnt==MAX_WAIT → grant req1.
  - else if req0_valid → grant req0.
  - else if req1_valid → grant req1.
  - else → no grant.
- wait_cnt (width 4):
  - Clears to 0 when req1 is granted or req1_valid=0.
  - Otherwise, while req1_valid=1 and req1 is not granted, increments and saturates at MAX_WAIT.
  - wb_hold cycles count as waiting.
- Output register, one-cycle latency from handshake to write:
  - On a grant: mux_sel <= granted index, wb_rd <= granted rd, wb_data <= granted data, wb_en <= (granted rd != 0).
  - With no grant: wb_en <= 0; mux_sel, wb_rd and wb_data hold their previous values.
- rd==0 write: the handshake completes (ready=1, arbitration state updates) but wb_en stays 0. x0 is never written.
- Back-to-back grants to either requester are allowed every cycle. There is no bubble between writes.
- Simultaneous valid with identical rd: only the winner writes this cycle. The loser writes in a later cycle, so the loser's value persists. Ordering is the issuer's responsibility.
- wb_hold rising while a write is registered: the already-registered wb_en pulse still completes. Only new grants are blocked.

Optional Feature:
- Macro: WB_ARB_RR_EN.
- Defined: pure round-robin arbitration.
  - 1-bit rr_ptr names the preferred requester (reset value 0).
  - Both valid → grant rr_ptr; one valid → grant it.
  - After any grant, rr_ptr <= ~granted index.
  - wait_cnt is not implemented; MAX_WAIT is ignored.
- Undefined: fixed-priority-with-aging as described above; rr_ptr is not implemented.

Test Plan:
- Reset: rst_n=0 for 2 cycles with both valid=1 → ready0=ready1=0; wb_en=0, wb_rd=0, wb_data=0, mux_sel=0 throughout and on the first cycle after release.
- Single write: req0_valid=1, rd=5, data=0xDEADBEEF for 1 cycle → ready0=1 that cycle; next cycle wb_en=1, wb_rd=5, wb_data=0xDEADBEEF, mux_sel=0; the following cycle wb_en=0.
- Aging (macro off, MAX_WAIT=4): both valid continuously, req0 rd=1..n, req1 rd=9 → req0 wins 4 cycles, req1 wins the 5th, and wb_rd=9 / mux_sel=1 appears one cycle later.
- Round-robin (macro on): both valid for 6 cycles → grants alternate 0,1,0,1,0,1; mux_sel follows the same sequence delayed one cycle.
- x0 and hold: req1 rd=0, data=0x1234 → ready1=1 and wb_en stays 0. Then wb_hold=1 for 3 cycles with req0_valid=1 → ready0=0 for those 3 cycles; ready0=1 on the first cycle after wb_hold falls.
- Reset mid-operation: grant req1 (rd=7) in cycle N with rst_n=0 in cycle N → wb_en=0 in cycle N+1 and register 7 is never written.
